// File: rtl/float_pack_normalizer_if.sv
// Handshake bundle between the FP arithmetic stage and the pack/normalize back end.
// master drives the unnormalized triple and consumes the packed result; slave is the normalizer.
interface float_pack_normalizer_if #(
    parameter int EXPONENT = 8,
    parameter int FRACTION = 23
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_sign;
    logic [EXPONENT+1:0]          in_exp;
    logic [FRACTION+4:0]          in_mant;
    logic                         in_inf;
    logic                         in_nan;
    logic                         out_valid;
    logic                         out_ready;
    logic [EXPONENT+FRACTION:0]   out_result;
    logic [3:0]                   out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_inf, in_nan, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_inf, in_nan, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/float_pack_normalizer.sv
// Normalizes a sign/exponent/mantissa triple one shift per cycle, rounds to nearest-even,
// flags overflow/underflow (flush to zero) and packs an IEEE-754 word. One op in flight.
module float_pack_normalizer #(
    parameter int EXPONENT = 8,
    parameter int FRACTION = 23
) (
    input logic                      clk,
    input logic                      rst_n,
    float_pack_normalizer_if.slave   bus
);
    localparam int EW = EXPONENT + 2;
    localparam int MW = FRACTION + 5;
    localparam int RW = 1 + EXPONENT + FRACTION;

    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXPONENT) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic [RW-2:0]        ZERO_MAG = '0;
    localparam logic [RW-1:0]        QNAN = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

    state_e                 state_q;
    logic                   sign_q, inf_q, nan_q, out_valid_q;
    logic signed [EW-1:0]   exp_q;
    logic [MW-1:0]          mant_q;
    logic [RW-1:0]          result_q;
    logic [3:0]             flags_q;

    logic                   rnd_inc, rnd_inexact;
    logic [FRACTION+1:0]    rnd_sum;
    logic signed [EW-1:0]   rnd_exp;
    logic [RW-1:0]          rnd_result_d;
    logic [3:0]             rnd_flags_d;

    // Round stage works on mant_q[26:3] with L/G/R/S at bits 3..0.
    always_comb begin
        rnd_inc      = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        rnd_inexact  = |mant_q[2:0];
        rnd_sum      = {1'b0, mant_q[MW-2:3]} + (FRACTION+2)'(rnd_inc);
        rnd_exp      = exp_q + EW'(rnd_sum[FRACTION+1]);
        rnd_result_d = {sign_q, rnd_exp[EXPONENT-1:0], rnd_sum[FRACTION-1:0]};
        rnd_flags_d  = {2'b00, rnd_inexact, 1'b0};
        if (rnd_exp >= E_MAX) begin
            rnd_result_d = {sign_q, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
            rnd_flags_d  = 4'b1010;
        end else if (rnd_exp <= E_ZERO) begin
            rnd_result_d = {sign_q, ZERO_MAG};
            rnd_flags_d  = 4'b0111;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.in_valid) begin
                    sign_q  <= bus.in_sign;
                    exp_q   <= bus.in_exp;
                    mant_q  <= bus.in_mant;
                    inf_q   <= bus.in_inf;
                    nan_q   <= bus.in_nan;
                    state_q <= NORM;
                end
                NORM: begin
                    if (nan_q) begin
                        result_q <= QNAN;
                        flags_q  <= '0;
                        state_q  <= DONE;
                    end else if (inf_q) begin
                        result_q <= {sign_q, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
                        flags_q  <= '0;
                        state_q  <= DONE;
                    end else if (mant_q == '0) begin
                        result_q <= {sign_q, ZERO_MAG};
                        flags_q  <= 4'b0001;
                        state_q  <= DONE;
                    end else if (mant_q[MW-1]) begin
                        // Carry: one right shift, folding the dropped bit into sticky.
                        mant_q  <= {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
                        exp_q   <= exp_q + E_ONE;
                        state_q <= ROUND;
                    end else if (!mant_q[MW-2]) begin
                        mant_q  <= {mant_q[MW-2:0], 1'b0};
                        exp_q   <= exp_q - E_ONE;
                    end else begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    result_q <= rnd_result_d;
                    flags_q  <= rnd_flags_d;
                    state_q  <= DONE;
                end
                DONE: begin
                    // out_valid is registered, so it rises one cycle after entering DONE.
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = rst_n && (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_flags  = flags_q;
endmodule

// File: tb/tb_float_pack_normalizer.sv
// Randomized scoreboard bench: the stimulus pushes reference results, a monitor pops and
// compares result, flags and latency on each output transfer.
module tb_float_pack_normalizer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float_pack_normalizer_if bus ();
    float_pack_normalizer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: value = mant * 2^(exp-26); normalize, round-half-even on 24 bits, range check.
    function automatic exp_t model(input logic s, input int e, input logic [27:0] m,
                                   input logic inf, input logic nan);
        exp_t x;
        longint nm, sig, rem;
        int p, k, ee;
        x.acc = 0; x.fl = 4'b0000; x.lat = 2;
        if (nan) begin x.res = 32'h7FC00000; return x; end
        if (inf) begin x.res = {s, 8'hFF, 23'h0}; return x; end
        if (m == 28'h0) begin x.res = {s, 31'h0}; x.fl = 4'b0001; return x; end
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        ee = e;
        if (p == 27) begin
            nm = (longint'(m) >> 1) | (longint'(m) & 64'd1);
            ee = ee + 1;
            x.lat = 3;
        end else begin
            k = 26 - p;
            nm = longint'(m) << k;
            ee = ee - k;
            x.lat = 3 + k;
        end
        sig = nm >> 3;
        rem = nm & 64'd7;
        if (rem > 4 || (rem == 4 && sig[0])) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin sig = 64'd1 << 23; ee = ee + 1; end
        if (ee >= 255) begin x.res = {s, 8'hFF, 23'h0}; x.fl = 4'b1010; end
        else if (ee <= 0) begin x.res = {s, 31'h0}; x.fl = 4'b0111; end
        else begin x.res = {s, ee[7:0], sig[22:0]}; x.fl = {2'b00, rem != 0, 1'b0}; end
        return x;
    endfunction

    task automatic issue(input logic s, input int e, input logic [27:0] m, input logic inf,
                         input logic nan, input exp_t x, input bit push);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 400) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin
            chk("accept_timeout", {31'h0, bus.in_ready}, 32'h1);
            return;
        end
        bus.in_valid = 1'b1; bus.in_sign = s; bus.in_exp = 10'(e);
        bus.in_mant = m; bus.in_inf = inf; bus.in_nan = nan;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        x.acc = cyc;
        if (push) q.push_back(x);
    endtask

    task automatic dv(input logic s, input int e, input logic [27:0] m, input logic inf,
                      input logic nan, input logic [31:0] r, input logic [3:0] f, input int lat);
        exp_t x;
        x.res = r; x.fl = f; x.lat = lat; x.acc = 0;
        issue(s, e, m, inf, nan, x, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !bus.in_ready) && n < 2000) begin @(negedge clk); n++; end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'h0);
    endtask

    // out_ready changes 2 time units after the rising edge, so negedge sampling is stable.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic prev = 1'b0;
        int   rise = 0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst_n) begin prev = 1'b0; continue; end
            if (bus.out_valid && !prev) rise = cyc;
            prev = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", bus.out_result, 32'hxxxxxxxx);
                end else begin
                    x = q.pop_front();
                    chk("result", bus.out_result, x.res);
                    chk("flags", {28'h0, bus.out_flags}, {28'h0, x.fl});
                    chk("latency", 32'(rise - x.acc), 32'(x.lat));
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        exp_t x;
        logic s, inf, nan;
        logic [27:0] m;
        int e, w, sel;
        bit saw;
        bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
        bus.in_inf = 1'b0; bus.in_nan = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_result", bus.out_result, 32'h0);
        chk("rst_flags", {28'h0, bus.out_flags}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

        dv(0, 127, 28'h1 << 26, 0, 0, 32'h3F800000, 4'b0000, 3);
        dv(0, 127, 28'h3 << 26, 0, 0, 32'h40400000, 4'b0000, 3);
        dv(0, 133, 28'h1 << 20, 0, 0, 32'h3F800000, 4'b0000, 9);
        dv(0, 127, (28'h1 << 26) | 28'h4, 0, 0, 32'h3F800000, 4'b0010, 3);
        dv(0, 127, (28'h1 << 26) | 28'hC, 0, 0, 32'h3F800002, 4'b0010, 3);
        dv(0, 254, 28'h7FFFFFC, 0, 0, 32'h7F800000, 4'b1010, 3);
        dv(1, 1, 28'h1 << 25, 0, 0, 32'h80000000, 4'b0111, 4);
        dv(0, 5, 28'h1234567, 0, 1, 32'h7FC00000, 4'b0000, 2);
        dv(1, 5, 28'h1234567, 1, 0, 32'hFF800000, 4'b0000, 2);
        dv(1, 5, 28'h0, 1, 1, 32'h7FC00000, 4'b0000, 2);
        dv(1, 90, 28'h0, 0, 0, 32'h80000000, 4'b0001, 2);
        dv(0, -26, 28'h1, 0, 0, 32'h00000000, 4'b0111, 29);
        dv(0, 256, 28'h1 << 26, 0, 0, 32'h7F800000, 4'b1010, 3);
        dv(0, 1, 28'h1 << 26, 0, 0, 32'h00800000, 4'b0000, 3);
        dv(1, 254, 28'h1 << 26, 0, 0, 32'hFF000000, 4'b0000, 3);

        drain();
        ready_mode = 2;
        dv(0, 127, 28'h1 << 26, 0, 0, 32'h3F800000, 4'b0000, 3);
        w = 0;
        while (!bus.out_valid && w < 50) begin @(negedge clk); w++; end
        chk("stall_valid_rise", {31'h0, bus.out_valid}, 32'h1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_result", bus.out_result, 32'h3F800000);
            chk("stall_in_ready", {31'h0, bus.in_ready}, 32'h0);
            chk("stall_valid", {31'h0, bus.out_valid}, 32'h1);
        end
        ready_mode = 0;

        drain();
        x = model(0, 133, 28'h1 << 20, 0, 0);
        issue(0, 133, 28'h1 << 20, 0, 0, x, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        chk("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("midrst_result", bus.out_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle", {31'h0, bus.in_ready}, 32'h1);
        saw = 1'b0;
        repeat (12) begin @(negedge clk); if (bus.out_valid) saw = 1'b1; end
        chk("midrst_no_output", {31'h0, saw}, 32'h0);

        ready_mode = 1;
        for (int n = 0; n < 300; n++) begin
            s = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 19));
            nan = (sel == 0);
            inf = (sel == 1);
            if ($urandom_range(0, 1) == 1) e = int'($urandom_range(100, 160));
            else e = int'($urandom_range(0, 282)) - 26;
            w = int'($urandom_range(1, 28));
            m = 28'($urandom);
            if (w < 28) m = m & ((28'h1 << w) - 28'h1);
            if (sel == 2) m = 28'h0;
            x = model(s, e, m, inf, nan);
            issue(s, e, m, inf, nan, x, 1'b1);
        end
        ready_mode = 0;
        drain();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
